// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester handshake plus SPI pins of the shared engine.
// master = arbiter side, slave = requesters / pad side.
interface spi_xfer_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] tx_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         rx_data;
   logic                      busy;
   logic                      spi_sck;
   logic                      spi_mosi;
   logic                      spi_miso;
   logic [NUM_REQ-1:0]        spi_cs_n;

   modport master (
      input  req, tx_data, spi_miso,
      output gnt, ack, rx_data, busy,
      output spi_sck, spi_mosi, spi_cs_n
   );

   modport slave (
      output req, tx_data, spi_miso,
      input  gnt, ack, rx_data, busy,
      input  spi_sck, spi_mosi, spi_cs_n
   );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one mode-0 SPI master engine.
// Option SPI_ARB_LOOPBACK_EN feeds spi_mosi back into the RX shifter.
module spi_xfer_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2
) (
   input logic clk,
   input logic rst,
   spi_xfer_arbiter_if.master bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int BW = $clog2(DATA_W + 1);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] HOLD_LAST = DW'(CLK_DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT, HOLD, DONE
   } state_t;

   state_t             state;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      gidx;
   logic [DW-1:0]      div;
   logic [BW-1:0]      bit_cnt;
   logic [DATA_W-1:0]  sreg;
   logic [DATA_W-1:0]  rreg;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] ack_q;
   logic [NUM_REQ-1:0] cs_n_q;
   logic [DATA_W-1:0]  rx_q;
   logic               busy_q;
   logic               sck_q;
   logic               mosi_q;

   logic [PW-1:0]      pick;
   logic               found;
   logic [DATA_W-1:0]  sreg_sh;
   logic [DATA_W-1:0]  tx_sel;
   logic               rx_in;

   // Scan downward so the closest request at or after ptr wins.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[(int'(ptr) + i) % NUM_REQ]) begin
            pick  = PW'((int'(ptr) + i) % NUM_REQ);
            found = 1'b1;
         end
      end
   end

   assign tx_sel  = bus.tx_data[int'(pick)*DATA_W +: DATA_W];
   assign sreg_sh = sreg << 1;

`ifdef SPI_ARB_LOOPBACK_EN
   assign rx_in = mosi_q;
`else
   assign rx_in = bus.spi_miso;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gidx    <= '0;
         div     <= '0;
         bit_cnt <= '0;
         sreg    <= '0;
         rreg    <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         cs_n_q  <= '1;
         rx_q    <= '0;
         busy_q  <= 1'b0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         ack_q <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  gidx    <= pick;
                  gnt_q   <= NUM_REQ'(1) << pick;
                  cs_n_q  <= ~(NUM_REQ'(1) << pick);
                  sreg    <= tx_sel;
                  mosi_q  <= tx_sel[DATA_W-1];
                  busy_q  <= 1'b1;
                  div     <= '0;
                  bit_cnt <= '0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (div == DIV_LAST) begin
                  div   <= '0;
                  state <= SHIFT;
               end else begin
                  div <= div + 1'b1;
               end
            end
            SHIFT: begin
               if (div != DIV_LAST) begin
                  div <= div + 1'b1;
               end else if (!sck_q) begin
                  div   <= '0;
                  sck_q <= 1'b1;
                  rreg  <= DATA_W'({rreg, rx_in});
               end else begin
                  div   <= '0;
                  sck_q <= 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= HOLD;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     sreg    <= sreg_sh;
                     mosi_q  <= sreg_sh[DATA_W-1];
                  end
               end
            end
            // Runs CLK_DIV+1 cycles so ack lands 2+2*CLK_DIV*(DATA_W+1) after grant.
            HOLD: begin
               if (div == HOLD_LAST) begin
                  div   <= '0;
                  state <= DONE;
               end else begin
                  div <= div + 1'b1;
               end
            end
            DONE: begin
               gnt_q  <= '0;
               cs_n_q <= '1;
               ack_q  <= gnt_q;
               rx_q   <= rreg;
               busy_q <= 1'b0;
               mosi_q <= 1'b0;
               ptr    <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.rx_data  = rx_q;
   assign bus.busy     = busy_q;
   assign bus.spi_sck  = sck_q;
   assign bus.spi_mosi = mosi_q;
   assign bus.spi_cs_n = cs_n_q;
endmodule
